// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared widths, constants, FSM encoding and buffer payload for the fetch stage.
package if_stage_pkg;

    localparam int unsigned ADDR_LEN = 32;
    localparam int unsigned INST_LEN = 32;

    localparam logic [INST_LEN-1:0] NOP_INST  = 32'h0000_0013;
    localparam logic [ADDR_LEN-1:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_WAIT = 2'd1,
        IF_DROP = 2'd2
    } if_state_e;

    // One-entry IF/ID output buffer
    typedef struct packed {
        logic [ADDR_LEN-1:0] pc;
        logic [INST_LEN-1:0] inst;
        logic                valid;
    } if_buf_t;

endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: instruction-memory request/response bus between fetch stage and memory controller.
interface if_stage_if;

    logic                                mem_req_o;
    logic [if_stage_pkg::ADDR_LEN-1:0]   mem_addr_o;
    logic                                mem_valid_i;
    logic [if_stage_pkg::INST_LEN-1:0]   mem_data_i;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        input  mem_valid_i,
        input  mem_data_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        output mem_valid_i,
        output mem_data_i
    );

endinterface

// File: rtl/if_stage_icache_dm.sv
// icache_dm: direct-mapped, one word per line instruction cache; valid bits cleared by async reset.
// LINES must be a power of two and at least 2.
module icache_dm
    import if_stage_pkg::*;
#(
    parameter int unsigned LINES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_LEN-1:0] lookup_addr_i,
    output logic                hit_c,
    output logic [INST_LEN-1:0] data_c,
    input  logic                fill_en_i,
    input  logic [ADDR_LEN-1:0] fill_addr_i,
    input  logic [INST_LEN-1:0] fill_data_i
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = ADDR_LEN - IDX_W - 2;

    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_mem  [LINES];
    logic [INST_LEN-1:0] data_mem [LINES];

    logic [IDX_W-1:0] lk_idx_c;
    logic [IDX_W-1:0] fl_idx_c;
    logic [TAG_W-1:0] lk_tag_c;
    logic [TAG_W-1:0] fl_tag_c;

    assign lk_idx_c = lookup_addr_i[IDX_W+1:2];
    assign lk_tag_c = lookup_addr_i[ADDR_LEN-1:IDX_W+2];
    assign fl_idx_c = fill_addr_i[IDX_W+1:2];
    assign fl_tag_c = fill_addr_i[ADDR_LEN-1:IDX_W+2];

    // Byte-offset bits never take part in a word-addressed lookup
    logic unused_c;
    assign unused_c = ^{lookup_addr_i[1:0], fill_addr_i[1:0]};

    assign hit_c  = valid_q[lk_idx_c] & (tag_mem[lk_idx_c] == lk_tag_c);
    assign data_c = data_mem[lk_idx_c];

    // Line valid bits: cleared on reset, set on fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (fill_en_i) begin
            valid_q[fl_idx_c] <= 1'b1;
        end
    end

    // Tag and data storage, written on fill only
    always_ff @(posedge clk) begin
        if (fill_en_i) begin
            tag_mem[fl_idx_c]  <= fl_tag_c;
            data_mem[fl_idx_c] <= fill_data_i;
        end
    end

endmodule

// File: rtl/if_stage.sv
// if_stage: RV32I instruction-fetch stage with one-entry IF/ID buffer and EX redirect.
// Optional feature macro: IF_ICACHE_EN enables the direct-mapped icache (icache_dm).
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [ADDR_LEN-1:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned         ICACHE_LINES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rdy,
    input  logic                stall_i,
    input  logic                br_taken_i,
    input  logic [ADDR_LEN-1:0] br_target_i,
    if_stage_if.master          mem,
    output logic [ADDR_LEN-1:0] pc_o,
    output logic [INST_LEN-1:0] inst_o,
    output logic                if_id_rdy_o
);

    if_state_e           state_q, state_d;
    logic [ADDR_LEN-1:0] pc_q, pc_d;
    logic                req_q, req_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    if_buf_t             buf_q, buf_d;

    logic                consume_c;
    logic                can_load_c;
    logic [ADDR_LEN-1:0] br_pc_c;
    logic                hit_c;
    logic [INST_LEN-1:0] hit_data_c;
    logic                fill_en_c;

    assign consume_c  = rdy & buf_q.valid & ~stall_i;
    assign can_load_c = ~buf_q.valid | consume_c;
    assign br_pc_c    = {br_target_i[ADDR_LEN-1:2], 2'b00};

`ifdef IF_ICACHE_EN
    icache_dm #(
        .LINES (ICACHE_LINES)
    ) u_icache (
        .clk           (clk),
        .rst_n         (rst_n),
        .lookup_addr_i (pc_q),
        .hit_c         (hit_c),
        .data_c        (hit_data_c),
        .fill_en_i     (fill_en_c),
        .fill_addr_i   (pc_q),
        .fill_data_i   (mem.mem_data_i)
    );

    logic unused_c;
    assign unused_c = ^br_target_i[1:0];
`else
    // No cache: never hit, every fetch goes to memory
    assign hit_c      = 1'b0;
    assign hit_data_c = NOP_INST;

    logic unused_c;
    assign unused_c = ^{br_target_i[1:0], fill_en_c, 1'(ICACHE_LINES)};
`endif

    // Next-state: fetch FSM, PC, request and output buffer; rdy=0 freezes everything
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_d     = req_q;
        addr_d    = addr_q;
        buf_d     = buf_q;
        fill_en_c = 1'b0;

        if (rdy) begin
            if (consume_c) begin
                buf_d.valid = 1'b0;
            end

            case (state_q)
                IF_IDLE: begin
                    if (br_taken_i) begin
                        pc_d        = br_pc_c;
                        buf_d.valid = 1'b0;
                    end else if (can_load_c) begin
                        if (hit_c) begin
                            buf_d.pc    = pc_q;
                            buf_d.inst  = hit_data_c;
                            buf_d.valid = 1'b1;
                            pc_d        = pc_q + ADDR_LEN'(4);
                        end else begin
                            req_d   = 1'b1;
                            addr_d  = pc_q;
                            state_d = IF_WAIT;
                        end
                    end
                end

                IF_WAIT: begin
                    if (br_taken_i) begin
                        pc_d        = br_pc_c;
                        buf_d.valid = 1'b0;
                        if (mem.mem_valid_i) begin
                            req_d   = 1'b0;
                            state_d = IF_IDLE;
                        end else begin
                            state_d = IF_DROP;
                        end
                    end else if (mem.mem_valid_i) begin
                        buf_d.pc    = pc_q;
                        buf_d.inst  = mem.mem_data_i;
                        buf_d.valid = 1'b1;
                        pc_d        = pc_q + ADDR_LEN'(4);
                        req_d       = 1'b0;
                        state_d     = IF_IDLE;
                        fill_en_c   = 1'b1;
                    end
                end

                IF_DROP: begin
                    if (br_taken_i) begin
                        pc_d        = br_pc_c;
                        buf_d.valid = 1'b0;
                    end
                    if (mem.mem_valid_i) begin
                        req_d   = 1'b0;
                        state_d = IF_IDLE;
                    end
                end

                default: begin
                    req_d   = 1'b0;
                    state_d = IF_IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IF_IDLE;
            pc_q        <= RESET_PC;
            req_q       <= 1'b0;
            addr_q      <= ZERO_WORD;
            buf_q.pc    <= ZERO_WORD;
            buf_q.inst  <= NOP_INST;
            buf_q.valid <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
        end
    end

    assign mem.mem_req_o  = req_q;
    assign mem.mem_addr_o = addr_q;
    assign pc_o           = buf_q.pc;
    assign inst_o         = buf_q.inst;
    assign if_id_rdy_o    = buf_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed self-checking bench for if_stage with a fixed-latency memory responder.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        stall_i;
    logic        br_taken_i;
    logic [31:0] br_target_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        if_id_rdy_o;

    int n_pass  = 0;
    int n_total = 0;
    int lat     = 3;
    int cnt;

    if_stage_if mem_bus ();

    if_stage #(
        .RESET_PC     (32'h0000_0000),
        .ICACHE_LINES (64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rdy         (rdy),
        .stall_i     (stall_i),
        .br_taken_i  (br_taken_i),
        .br_target_i (br_target_i),
        .mem         (mem_bus),
        .pc_o        (pc_o),
        .inst_o      (inst_o),
        .if_id_rdy_o (if_id_rdy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return 32'hA500_0000 ^ a;
    endfunction

    // Memory responder: valid pulse 'lat' cycles after the request rises; frozen when rdy=0
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_bus.mem_valid_i <= 1'b0;
            mem_bus.mem_data_i  <= 32'h0;
            cnt                 <= 0;
        end else if (rdy) begin
            mem_bus.mem_valid_i <= 1'b0;
            if (mem_bus.mem_req_o && !mem_bus.mem_valid_i) begin
                if (cnt >= lat - 1) begin
                    mem_bus.mem_valid_i <= 1'b1;
                    mem_bus.mem_data_i  <= data_of(mem_bus.mem_addr_o);
                    cnt                 <= 0;
                end else begin
                    cnt <= cnt + 1;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 40; i++) begin
            if (mem_bus.mem_req_o) return;
            tick();
        end
        n_total++;
        $display("FAIL %s: timeout waiting for mem_req_o", name);
    endtask

    task automatic wait_buf(input string name);
        for (int i = 0; i < 40; i++) begin
            if (if_id_rdy_o) return;
            tick();
        end
        n_total++;
        $display("FAIL %s: timeout waiting for if_id_rdy_o", name);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rdy = 1'b1; stall_i = 1'b0; br_taken_i = 1'b0; br_target_i = 32'h0;
        lat = 3;
        tick();
        tick();
        n_total++;
        if ({mem_bus.mem_req_o, mem_bus.mem_addr_o} !== {1'b0, 32'h0})
            $display("FAIL reset_req: got req=%b addr=%h expected req=0 addr=0",
                     mem_bus.mem_req_o, mem_bus.mem_addr_o);
        else n_pass++;
        n_total++;
        if ({if_id_rdy_o, pc_o, inst_o} !== {1'b0, 32'h0, 32'h0000_0013})
            $display("FAIL reset_buf: got rdy=%b pc=%h inst=%h expected 0/0/00000013",
                     if_id_rdy_o, pc_o, inst_o);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        for (int k = 0; k < 4; k++) begin
            wait_req("stream_req");
            n_total++;
            if (mem_bus.mem_addr_o !== 32'(4 * k))
                $display("FAIL stream_addr: got %h expected %h", mem_bus.mem_addr_o, 32'(4 * k));
            else n_pass++;
            wait_buf("stream_buf");
            n_total++;
            if ({pc_o, inst_o} !== {32'(4 * k), data_of(32'(4 * k))})
                $display("FAIL stream_word: got pc=%h inst=%h expected pc=%h inst=%h",
                         pc_o, inst_o, 32'(4 * k), data_of(32'(4 * k)));
            else n_pass++;
            tick();
            n_total++;
            if (if_id_rdy_o !== 1'b0)
                $display("FAIL stream_pulse: got rdy=%b expected 0", if_id_rdy_o);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        stall_i = 1'b1;
        wait_buf("stall_buf");
        n_total++;
        if ({pc_o, inst_o} !== {32'h10, data_of(32'h10)})
            $display("FAIL stall_load: got pc=%h inst=%h expected pc=00000010 inst=%h",
                     pc_o, inst_o, data_of(32'h10));
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_total++;
            if ({if_id_rdy_o, pc_o, inst_o, mem_bus.mem_req_o} !== {1'b1, 32'h10, data_of(32'h10), 1'b0})
                $display("FAIL stall_hold: got rdy=%b pc=%h inst=%h req=%b expected 1/00000010/%h/0",
                         if_id_rdy_o, pc_o, inst_o, mem_bus.mem_req_o, data_of(32'h10));
            else n_pass++;
        end
        stall_i = 1'b0;
        tick();
        n_total++;
        if ({mem_bus.mem_req_o, mem_bus.mem_addr_o, if_id_rdy_o} !== {1'b1, 32'h14, 1'b0})
            $display("FAIL stall_release: got req=%b addr=%h rdy=%b expected 1/00000014/0",
                     mem_bus.mem_req_o, mem_bus.mem_addr_o, if_id_rdy_o);
        else n_pass++;
    endtask

    task automatic test_redirect_wait();
        bit leaked = 1'b0;
        bit found  = 1'b0;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            wait_req("redir_pre_req");
            wait_buf("redir_pre_buf");
            tick();
        end
        wait_req("redir_req8");
        n_total++;
        if (mem_bus.mem_addr_o !== 32'h8)
            $display("FAIL redir_addr8: got %h expected 00000008", mem_bus.mem_addr_o);
        else n_pass++;
        br_taken_i = 1'b1; br_target_i = 32'h0000_0104;
        tick();
        br_taken_i = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if ((if_id_rdy_o && pc_o == 32'h8) || inst_o == data_of(32'h8)) leaked = 1'b1;
            if (mem_bus.mem_req_o && mem_bus.mem_addr_o == 32'h104) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        n_total++;
        if ({leaked, found} !== 2'b01)
            $display("FAIL redir_drop: got leaked=%b found_req104=%b expected 0/1", leaked, found);
        else n_pass++;
        wait_buf("redir_buf");
        n_total++;
        if ({pc_o, inst_o} !== {32'h104, data_of(32'h104)})
            $display("FAIL redir_word: got pc=%h inst=%h expected pc=00000104 inst=%h",
                     pc_o, inst_o, data_of(32'h104));
        else n_pass++;
    endtask

    task automatic test_redirect_valid();
        for (int i = 0; i < 30; i++) begin
            if (mem_bus.mem_valid_i) break;
            tick();
        end
        n_total++;
        if ({mem_bus.mem_valid_i, mem_bus.mem_addr_o} !== {1'b1, 32'h108})
            $display("FAIL rv_setup: got valid=%b addr=%h expected 1/00000108",
                     mem_bus.mem_valid_i, mem_bus.mem_addr_o);
        else n_pass++;
        br_taken_i = 1'b1; br_target_i = 32'h0000_0200;
        tick();
        br_taken_i = 1'b0;
        n_total++;
        if ({if_id_rdy_o, mem_bus.mem_req_o, inst_o} !== {1'b0, 1'b0, data_of(32'h104)})
            $display("FAIL rv_discard: got rdy=%b req=%b inst=%h expected 0/0/%h",
                     if_id_rdy_o, mem_bus.mem_req_o, inst_o, data_of(32'h104));
        else n_pass++;
        tick();
        n_total++;
        if ({mem_bus.mem_req_o, mem_bus.mem_addr_o} !== {1'b1, 32'h200})
            $display("FAIL rv_next_req: got req=%b addr=%h expected 1/00000200",
                     mem_bus.mem_req_o, mem_bus.mem_addr_o);
        else n_pass++;
    endtask

    task automatic test_wrap();
        bit found = 1'b0;
        do_reset();
        wait_req("wrap_req0");
        br_taken_i = 1'b1; br_target_i = 32'hFFFF_FFFF;
        tick();
        br_taken_i = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (mem_bus.mem_req_o && mem_bus.mem_addr_o == 32'hFFFF_FFFC) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        n_total++;
        if (found !== 1'b1)
            $display("FAIL wrap_align: got addr=%h expected FFFFFFFC", mem_bus.mem_addr_o);
        else n_pass++;
        wait_buf("wrap_buf");
        n_total++;
        if (pc_o !== 32'hFFFF_FFFC)
            $display("FAIL wrap_pc: got %h expected FFFFFFFC", pc_o);
        else n_pass++;
        tick();
        n_total++;
        if ({mem_bus.mem_req_o, mem_bus.mem_addr_o} !== {1'b1, 32'h0})
            $display("FAIL wrap_next: got req=%b addr=%h expected 1/00000000",
                     mem_bus.mem_req_o, mem_bus.mem_addr_o);
        else n_pass++;
    endtask

`ifdef IF_ICACHE_EN
    task automatic test_icache();
        do_reset();
        lat = 1;
        for (int k = 0; k < 4; k++) begin
            wait_buf("ic_pass1");
            n_total++;
            if (pc_o !== 32'(4 * k))
                $display("FAIL ic_pass1_pc: got %h expected %h", pc_o, 32'(4 * k));
            else n_pass++;
            if (k < 3) tick();
        end
        br_taken_i = 1'b1; br_target_i = 32'h0;
        tick();
        br_taken_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_total++;
            if ({if_id_rdy_o, pc_o, inst_o, mem_bus.mem_req_o} !== {1'b1, 32'(4 * k), data_of(32'(4 * k)), 1'b0})
                $display("FAIL ic_pass2: got rdy=%b pc=%h inst=%h req=%b expected 1/%h/%h/0",
                         if_id_rdy_o, pc_o, inst_o, mem_bus.mem_req_o, 32'(4 * k), data_of(32'(4 * k)));
            else n_pass++;
        end
        lat = 3;
    endtask
`endif

    task automatic test_rdy_and_reset();
        do_reset();
        lat = 3;
        wait_buf("rdy_buf0");
        rdy = 1'b0;
        br_taken_i = 1'b1; br_target_i = 32'h300;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_total++;
            if ({if_id_rdy_o, pc_o, mem_bus.mem_req_o} !== {1'b1, 32'h0, 1'b0})
                $display("FAIL rdy_hold_buf: got rdy=%b pc=%h req=%b expected 1/00000000/0",
                         if_id_rdy_o, pc_o, mem_bus.mem_req_o);
            else n_pass++;
        end
        rdy = 1'b1; br_taken_i = 1'b0;
        tick();
        n_total++;
        if ({mem_bus.mem_req_o, mem_bus.mem_addr_o, if_id_rdy_o} !== {1'b1, 32'h4, 1'b0})
            $display("FAIL rdy_resume: got req=%b addr=%h rdy=%b expected 1/00000004/0",
                     mem_bus.mem_req_o, mem_bus.mem_addr_o, if_id_rdy_o);
        else n_pass++;
        tick();
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_total++;
            if ({mem_bus.mem_req_o, mem_bus.mem_addr_o, if_id_rdy_o} !== {1'b1, 32'h4, 1'b0})
                $display("FAIL rdy_hold_wait: got req=%b addr=%h rdy=%b expected 1/00000004/0",
                         mem_bus.mem_req_o, mem_bus.mem_addr_o, if_id_rdy_o);
            else n_pass++;
        end
        rdy = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({mem_bus.mem_req_o, mem_bus.mem_addr_o, if_id_rdy_o, pc_o, inst_o} !==
            {1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_0013})
            $display("FAIL mid_reset: got req=%b addr=%h rdy=%b pc=%h inst=%h expected 0/0/0/0/00000013",
                     mem_bus.mem_req_o, mem_bus.mem_addr_o, if_id_rdy_o, pc_o, inst_o);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        wait_req("restart_req");
        n_total++;
        if (mem_bus.mem_addr_o !== 32'h0)
            $display("FAIL restart_addr: got %h expected 00000000", mem_bus.mem_addr_o);
        else n_pass++;
        wait_buf("restart_buf");
        n_total++;
        if ({pc_o, inst_o} !== {32'h0, data_of(32'h0)})
            $display("FAIL restart_word: got pc=%h inst=%h expected 00000000/%h",
                     pc_o, inst_o, data_of(32'h0));
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_valid();
        test_wrap();
`ifdef IF_ICACHE_EN
        test_icache();
`endif
        test_rdy_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
